// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect -> FAULT).
package pc_pkg;

   // Control state of the PC unit
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   // Source of the next fetch address
   typedef enum logic [2:0] {
      SEL_SEQ  = 3'd0,
      SEL_JB   = 3'd1,
      SEL_JALR = 3'd2,
      SEL_TRAP = 3'd3,
      SEL_HOLD = 3'd4
   } sel_t;

   // Low address bits that must be zero for a 4-byte aligned fetch
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   // True when any of the alignment-checked low bits is set
   function automatic logic lsbs_misaligned(input logic [1:0] lsbs);
      return |(lsbs & ALIGN_MASK);
   endfunction

endpackage : pc_pkg

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC priority encoder (trap > jalr > jal/branch > sequential)
// plus redirect target alignment handling.
// Optional feature macro: PC_MISALIGN_TRAP_EN. When defined, a misaligned
// jalr/jal/branch target is flagged instead of being force-aligned.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            i_run,
   input  logic            i_trap_req,
   input  logic            i_take_jalr,
   input  logic            i_take_jb,
   input  logic            i_accept,
   input  logic [XLEN-1:0] i_normal_pc,
   input  logic [XLEN-1:0] i_jb_pc,
   input  logic [XLEN-1:0] i_alu_out,
   input  logic [XLEN-1:0] i_trap_vec,
   output sel_t            o_sel,
   output logic [XLEN-1:0] o_target,
   output logic            o_misaligned
);

   logic [XLEN-1:0] w_raw_target;
   logic            w_redirect;

   // Priority select; outside RUN the PC is never advanced from here
   always_comb begin
      o_sel = SEL_HOLD;
      if (i_run) begin
         if (i_trap_req)       o_sel = SEL_TRAP;
         else if (i_take_jalr) o_sel = SEL_JALR;
         else if (i_take_jb)   o_sel = SEL_JB;
         else if (i_accept)    o_sel = SEL_SEQ;
      end
   end

   // Raw target per source; jalr always drops bit 0 first
   always_comb begin
      w_raw_target = i_normal_pc;
      case (o_sel)
         SEL_TRAP: w_raw_target = i_trap_vec;
         SEL_JALR: w_raw_target = i_alu_out & ~XLEN'(1);
         SEL_JB:   w_raw_target = i_jb_pc;
         default:  w_raw_target = i_normal_pc;
      endcase
   end

   assign w_redirect = (o_sel == SEL_JALR) || (o_sel == SEL_JB);

`ifdef PC_MISALIGN_TRAP_EN
   // Misaligned jump targets are reported, not loaded; trap vectors are unchecked
   always_comb begin
      o_target     = w_raw_target;
      o_misaligned = w_redirect & lsbs_misaligned(w_raw_target[1:0]);
   end
`else
   // Jump targets are force-aligned; trap vectors pass through unchanged
   always_comb begin
      o_target     = w_redirect ? (w_raw_target & ~XLEN'(ALIGN_MASK)) : w_raw_target;
      o_misaligned = 1'b0;
   end
`endif

endmodule : pc_next_sel

// File: rtl/pc_gen.sv
// pc_gen: program-counter unit with fetch handshake, stall, boot cycle,
// misalignment fault state and accepted-fetch counter.
// Optional feature macro: PC_MISALIGN_TRAP_EN. Without it FAULT is
// unreachable and misalign_err stays 0.
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(32'h8000_0000),
   parameter int unsigned     ILEN_BYTES = 4,
   parameter int unsigned     CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  alu_out,
   input  logic             take_jb,
   input  logic             take_jalr,
   input  logic             trap_req,
   input  logic [XLEN-1:0]  trap_vec,
   input  logic             stall,
   input  logic             fetch_ready,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  normal_pc,
   output logic [XLEN-1:0]  jal_branch_pc,
   output logic             fetch_valid,
   output logic             misalign_err,
   output logic [CNT_W-1:0] fetch_cnt
);

   state_t           r_state;
   logic [XLEN-1:0]  r_pc;
   logic             r_fetch_valid;
   logic             r_misalign_err;
   logic [CNT_W-1:0] r_fetch_cnt;

   logic             w_accept;
   sel_t             w_sel;
   logic [XLEN-1:0]  w_target;
   logic             w_misaligned;

   // Candidate addresses, modulo 2^XLEN
   assign normal_pc     = r_pc + XLEN'(ILEN_BYTES);
   assign jal_branch_pc = r_pc + imm;

   // fetch_valid is only ever high in RUN, so this is a RUN-only accept
   assign w_accept = r_fetch_valid & fetch_ready & ~stall;

   pc_next_sel #(
      .XLEN (XLEN)
   ) u_next_sel (
      .i_run        (r_state == RUN),
      .i_trap_req   (trap_req),
      .i_take_jalr  (take_jalr),
      .i_take_jb    (take_jb),
      .i_accept     (w_accept),
      .i_normal_pc  (normal_pc),
      .i_jb_pc      (jal_branch_pc),
      .i_alu_out    (alu_out),
      .i_trap_vec   (trap_vec),
      .o_sel        (w_sel),
      .o_target     (w_target),
      .o_misaligned (w_misaligned)
   );

   // State machine, PC register, registered handshake/fault flags and fetch counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= BOOT;
         r_pc           <= RESET_VEC;
         r_fetch_valid  <= 1'b0;
         r_misalign_err <= 1'b0;
         r_fetch_cnt    <= '0;
      end else begin
         if (w_accept) begin
            r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
         end
         case (r_state)
            BOOT: begin
               r_state       <= RUN;
               r_fetch_valid <= 1'b1;
            end
            RUN: begin
               if (w_misaligned) begin
                  r_state        <= FAULT;
                  r_fetch_valid  <= 1'b0;
                  r_misalign_err <= 1'b1;
               end else if (w_sel != SEL_HOLD) begin
                  r_pc <= w_target;
               end
            end
            FAULT: begin
               if (trap_req) begin
                  r_state        <= RUN;
                  r_pc           <= trap_vec;
                  r_fetch_valid  <= 1'b1;
                  r_misalign_err <= 1'b0;
               end
            end
            default: begin
               r_state       <= BOOT;
               r_fetch_valid <= 1'b0;
            end
         endcase
      end
   end

   assign pc           = r_pc;
   assign fetch_valid  = r_fetch_valid;
   assign misalign_err = r_misalign_err;
   assign fetch_cnt    = r_fetch_cnt;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed literal checks plus randomized stimulus against a
// behavioural next-PC model. Honors PC_MISALIGN_TRAP_EN when defined.
module tb_pc_gen;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 4;
   localparam logic [31:0] RV    = 32'h8000_0000;

   localparam int M_BOOT  = 0;
   localparam int M_RUN   = 1;
   localparam int M_FAULT = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      imm, alu_out, trap_vec;
   logic             take_jb, take_jalr, trap_req, stall, fetch_ready;
   logic [31:0]      pc, normal_pc, jal_branch_pc;
   logic             fetch_valid, misalign_err;
   logic [CNT_W-1:0] fetch_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Behavioural model state
   logic [31:0] m_pc;
   int          m_mode;
   int          m_cnt;
   logic        m_err;

   always #5 clk = ~clk;

   pc_gen #(
      .XLEN       (XLEN),
      .RESET_VEC  (RV),
      .ILEN_BYTES (4),
      .CNT_W      (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imm           (imm),
      .alu_out       (alu_out),
      .take_jb       (take_jb),
      .take_jalr     (take_jalr),
      .trap_req      (trap_req),
      .trap_vec      (trap_vec),
      .stall         (stall),
      .fetch_ready   (fetch_ready),
      .pc            (pc),
      .normal_pc     (normal_pc),
      .jal_branch_pc (jal_branch_pc),
      .fetch_valid   (fetch_valid),
      .misalign_err  (misalign_err),
      .fetch_cnt     (fetch_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Next state from the rules: reset, one boot cycle, priority redirects, accepts
   task automatic model_step();
      logic [31:0] t;
      bit          redir;
      bit          acc;
      if (rst) begin
         m_pc = RV; m_mode = M_BOOT; m_cnt = 0; m_err = 1'b0;
      end else if (m_mode == M_BOOT) begin
         m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         acc   = fetch_ready && !stall;
         redir = 1'b0;
         t     = '0;
         if (acc) m_cnt = (m_cnt + 1) % 16;
         if (trap_req) m_pc = trap_vec;
         else begin
            if (take_jalr)    begin t = alu_out & ~32'd1; redir = 1'b1; end
            else if (take_jb) begin t = m_pc + imm;       redir = 1'b1; end
            else if (acc)     m_pc = m_pc + 32'd4;
            if (redir) begin
`ifdef PC_MISALIGN_TRAP_EN
               if (t % 4 != 0) begin m_mode = M_FAULT; m_err = 1'b1; end
               else m_pc = t;
`else
               m_pc = t - (t % 4);
`endif
            end
         end
      end else begin
         if (trap_req) begin m_pc = trap_vec; m_err = 1'b0; m_mode = M_RUN; end
      end
   endtask

   always @(posedge clk) model_step();

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_pc", pc, m_pc);
         chk("model_normal_pc", normal_pc, m_pc + 32'd4);
         chk("model_jb_pc", jal_branch_pc, m_pc + imm);
         chk("model_fetch_valid", 32'(fetch_valid), 32'(m_mode == M_RUN));
         chk("model_misalign_err", 32'(misalign_err), 32'(m_err));
         chk("model_fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      take_jb = 1'b0; take_jalr = 1'b0; trap_req = 1'b0; stall = 1'b0;
   endtask

   initial begin
      rst = 1'b1; imm = '0; alu_out = '0; trap_vec = '0;
      clear_ctl();
      fetch_ready = 1'b1;

      // Reset and boot cycle
      tick();
      chk_en = 1'b1;
      rst = 1'b0;
      chk("rst_pc", pc, 32'h8000_0000);
      chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
      chk("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
      chk("rst_misalign_err", 32'(misalign_err), 32'd0);
      tick();
      chk("run_pc0", pc, 32'h8000_0000);
      chk("run_valid", 32'(fetch_valid), 32'd1);
      tick(); chk("seq_pc4", pc, 32'h8000_0004);
      tick(); chk("seq_pc8", pc, 32'h8000_0008);
      tick(); chk("seq_cnt3", 32'(fetch_cnt), 32'd3);
      tick(); chk("seq_pc10", pc, 32'h8000_0010);

      // Backward branch wraps through the adder
      imm = 32'hFFFF_FFF0; take_jb = 1'b1;
      #1 chk("jb_target", jal_branch_pc, 32'h8000_0000);
      tick(); chk("jb_pc", pc, 32'h8000_0000);
      chk("jb_cnt", 32'(fetch_cnt), 32'd5);

      // jalr clears bit 0 and beats jal/branch
      take_jalr = 1'b1; alu_out = 32'h8000_0101;
      tick(); chk("jalr_pc", pc, 32'h8000_0100);

      // Trap beats everything
      trap_req = 1'b1; trap_vec = 32'h8000_0200;
      tick(); chk("trap_pc", pc, 32'h8000_0200);
      chk("trap_cnt", 32'(fetch_cnt), 32'd7);

      // Stall holds pc and counter
      clear_ctl(); stall = 1'b1;
      repeat (3) begin
         tick();
         chk("stall_pc", pc, 32'h8000_0200);
         chk("stall_cnt", 32'(fetch_cnt), 32'd7);
      end

      // Branch to 0x8000_0006
      clear_ctl(); take_jb = 1'b1; imm = 32'hFFFF_FE06;
      tick();
`ifdef PC_MISALIGN_TRAP_EN
      chk("mis_pc_hold", pc, 32'h8000_0200);
      chk("mis_valid", 32'(fetch_valid), 32'd0);
      chk("mis_err", 32'(misalign_err), 32'd1);
      clear_ctl();
      tick(); chk("fault_hold", pc, 32'h8000_0200);
      trap_req = 1'b1; trap_vec = 32'h8000_0300;
      tick();
      chk("fault_trap_pc", pc, 32'h8000_0300);
      chk("fault_err_clr", 32'(misalign_err), 32'd0);
      chk("fault_valid", 32'(fetch_valid), 32'd1);
`else
      chk("align_pc", pc, 32'h8000_0004);
      chk("align_err", 32'(misalign_err), 32'd0);
`endif

      // Sequential wrap at the top of the address space
      clear_ctl(); trap_req = 1'b1; trap_vec = 32'hFFFF_FFFC;
      tick();
      chk("top_pc", pc, 32'hFFFF_FFFC);
      chk("top_normal_pc", normal_pc, 32'h0000_0000);
      clear_ctl();
      tick(); chk("wrap_pc", pc, 32'h0000_0000);

      // Counter wraps modulo 2^CNT_W
      rst = 1'b1; tick(); rst = 1'b0;
      tick();
      repeat (17) tick();
      chk("cnt_wrap", 32'(fetch_cnt), 32'd1);
      chk("cnt_wrap_pc", pc, 32'h8000_0044);

      // Reset overrides stall and trap
      stall = 1'b1; trap_req = 1'b1; trap_vec = 32'h1234_5678; rst = 1'b1;
      tick();
      chk("rst_mid_pc", pc, 32'h8000_0000);
      chk("rst_mid_valid", 32'(fetch_valid), 32'd0);
      chk("rst_mid_cnt", 32'(fetch_cnt), 32'd0);
      rst = 1'b0; clear_ctl();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 149) == 0);
         trap_req    = ($urandom_range(0, 9) == 0);
         take_jalr   = ($urandom_range(0, 5) == 0);
         take_jb     = ($urandom_range(0, 3) == 0);
         stall       = ($urandom_range(0, 4) == 0);
         fetch_ready = ($urandom_range(0, 3) != 0);
         imm         = ($urandom_range(0, 1) == 1) ? $urandom : (($urandom & 32'h0000_0FFF) - 32'h800);
         alu_out     = $urandom;
         trap_vec    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pc_gen
